// File: rtl/rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
package rca_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational ripple-carry slice; also exposes the carry into its MSB for overflow.
module rca_slice #(
    parameter int SW = 4
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          c_msb_in
);

    logic [SW:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < SW; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = carry[SW];
    assign c_msb_in = carry[SW-1];

endmodule

// File: rtl/pipelined_rca_addsub.sv
// Pipelined ripple-carry add/sub: one SW-bit slice per stage, carry registered between
// stages, bubble-collapsing valid/ready flow control.
module pipelined_rca_addsub
    import rca_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int SW = slice_width(WIDTH, STAGES);
    localparam int YN = (STAGES > 1) ? STAGES - 1 : 1;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] adv;
    // x_q packs finished sum slices (top) with the not-yet-added part of A (bottom)
    logic [WIDTH-1:0]  x_q [STAGES];
    logic [WIDTH-1:0]  y_q [YN];
    logic              ovf_q;
    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;

    assign b_eff   = (op_e'(in_sub) == OP_SUB) ? ~in_b : in_b;
    assign cin_eff = (op_e'(in_sub) == OP_SUB) ? 1'b1 : in_cin;

    // A stage may load if it is empty or everything downstream moves this cycle
    always_comb begin
        logic run;
        run = out_ready;
        adv = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            run    = run | ~v_q[k];
            adv[k] = run;
        end
    end

    assign in_ready = adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] x_src;
        logic [WIDTH-1:0] x_next;
        logic [WIDTH-1:0] y_src;
        logic [SW-1:0]    s_sl;
        logic             c_src;
        logic             v_src;
        logic             c_out;
        logic             c_msb;

        if (k == 0) begin : g_head
            assign x_src = in_a;
            assign y_src = b_eff;
            assign c_src = cin_eff;
            assign v_src = in_valid;
        end else begin : g_body
            assign x_src = x_q[k-1];
            assign y_src = y_q[k-1];
            assign c_src = c_q[k-1];
            assign v_src = v_q[k-1];
        end

        rca_slice #(.SW(SW)) u_slice (
            .a        (x_src[SW-1:0]),
            .b        (y_src[SW-1:0]),
            .cin      (c_src),
            .sum      (s_sl),
            .cout     (c_out),
            .c_msb_in (c_msb)
        );

        if (STAGES == 1) begin : g_one
            assign x_next = s_sl;
        end else begin : g_multi
            assign x_next = {s_sl, x_src[WIDTH-1:SW]};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                x_q[k] <= '0;
            end else if (adv[k]) begin
                v_q[k] <= v_src;
                c_q[k] <= c_out;
                x_q[k] <= x_next;
            end
        end

        if (k < STAGES - 1) begin : g_mid
            logic unused_c_msb;
            assign unused_c_msb = c_msb;

            always_ff @(posedge clk) begin
                if (rst) begin
                    y_q[k] <= '0;
                end else if (adv[k]) begin
                    y_q[k] <= y_src >> SW;
                end
            end
        end else begin : g_last
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv[k]) begin
                    ovf_q <= c_msb ^ c_out;
                end
            end

            if (STAGES > 1) begin : g_sink
                logic unused_y_hi;
                assign unused_y_hi = ^y_src[WIDTH-1:SW];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_sum   = x_q[STAGES-1];
    assign out_cout  = c_q[STAGES-1];
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_rca_addsub.sv
// Directed and random checks of pipelined_rca_addsub against a 17-bit reference sum.
module tb_pipelined_rca_addsub;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic              in_cin;
    logic              in_sub;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_sum;
    logic              out_cout;
    logic              out_ovf;

    int                n_checks = 0;
    int                n_errors = 0;
    int                n_in     = 0;
    int                n_out    = 0;
    logic [17:0]       exp_q [$];

    logic [15:0]       s_a   [8];
    logic [15:0]       s_exp [8];
    logic              s_cout[8];

    always #5 clk = ~clk;

    pipelined_rca_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] bb;
        logic [16:0] r;
        logic        ovf;
        bb  = sub ? ~b : b;
        r   = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
        ovf = (a[15] == bb[15]) && (r[15] != a[15]);
        return {ovf, r[16], r[15:0]};
    endfunction

    // Scoreboard: transfers are sampled mid-cycle, when handshake signals are settled
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_out", 32'd1, 32'd0);
                end else begin
                    check("sb_result", {14'd0, out_ovf, out_cout, out_sum}, {14'd0, exp_q.pop_front()});
                end
            end
            if (in_valid && in_ready) begin
                n_in++;
                exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    task automatic send_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sub,
                            input logic [15:0] es, input logic ec, input logic eo);
        int cyc;
        @(posedge clk); #1;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            if (cyc == 0) in_valid = 1'b0;
            cyc++;
        end while (!out_valid && cyc < 20);
        check({tag, "_latency"}, cyc, 4);
        check({tag, "_sum"}, out_sum, es);
        check({tag, "_cout"}, out_cout, ec);
        check({tag, "_ovf"}, out_ovf, eo);
    endtask

    initial begin
        int          i;
        int          k;
        int          seen;
        int          sent;
        int          in0;
        int          out0;
        logic        acc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_cout", out_cout, 0);
        check("rst_out_ovf", out_ovf, 0);

        send_one("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send_one("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        send_one("sub_borrow", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        send_one("add_cin",    16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        send_one("sub_cin_ign",16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
        send_one("add_plain",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        send_one("add_negovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Streaming with a three-cycle output stall; each operand plus 0x0101
        s_a[0] = 16'h0000; s_exp[0] = 16'h0101; s_cout[0] = 1'b0;
        s_a[1] = 16'h1111; s_exp[1] = 16'h1212; s_cout[1] = 1'b0;
        s_a[2] = 16'h2222; s_exp[2] = 16'h2323; s_cout[2] = 1'b0;
        s_a[3] = 16'h3333; s_exp[3] = 16'h3434; s_cout[3] = 1'b0;
        s_a[4] = 16'h4444; s_exp[4] = 16'h4545; s_cout[4] = 1'b0;
        s_a[5] = 16'h5555; s_exp[5] = 16'h5656; s_cout[5] = 1'b0;
        s_a[6] = 16'h6666; s_exp[6] = 16'h6767; s_cout[6] = 1'b0;
        s_a[7] = 16'hFF00; s_exp[7] = 16'h0001; s_cout[7] = 1'b1;
        i = 0; k = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= 5 && c <= 7);
            in_valid  = (i < 8);
            if (i < 8) begin
                in_a = s_a[i]; in_b = 16'h0101; in_cin = 1'b0; in_sub = 1'b0;
            end
            #1;
            if (c >= 5 && c <= 7) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
                check("stall_out_sum", out_sum, s_exp[1]);
            end
            if (c == 8) check("full_accept_emit", {in_ready, out_valid}, 2'b11);
            if (out_valid && out_ready) begin
                if (k < 8) begin
                    check("stream_result", {out_cout, out_sum}, {s_cout[k], s_exp[k]});
                    check("stream_cycle", c, (k == 0) ? 4 : 7 + k);
                end
                k++;
            end
            if (in_valid && in_ready) i++;
        end
        in_valid = 1'b0;
        check("stream_count", k, 8);

        // Reset with three operations in flight
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; out_ready = 1'b1;
            in_a = 16'h1000 * c[15:0]; in_b = 16'h0007; in_cin = 1'b0; in_sub = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_sum", out_sum, 0);
        check("midrst_cout_ovf", {out_cout, out_ovf}, 2'b00);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("midrst_no_stale", seen, 0);

        // Random traffic; operands are held while a transfer is pending
        in0 = n_in; out0 = n_out;
        sent = 0; acc = 1'b0;
        for (int c = 0; c < 40000 && sent < 10000; c++) begin
            @(posedge clk); #1;
            if (!in_valid || acc) begin
                if ($urandom_range(0, 9) < 7) begin
                    in_valid = 1'b1;
                    in_a   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                    in_b   = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                    in_cin = 1'($urandom);
                    in_sub = 1'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            acc = in_valid && in_ready;
            if (acc) sent++;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("rand_sent", sent, 10000);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
        end
        check("rand_drained", exp_q.size(), 0);
        check("rand_in_out_count", n_out - out0, n_in - in0);
        check("rand_idle_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
